wb_arbiter: RTL and testbench

Write-back port arbiter for the register file's single write port (`rd_wena_WB` / `rd_addr_WB` / `rd_data_WB`). It sits between the in-order pipeline result (MEM/WB path) and the out-of-order-completing multi-cycle units (MUL, DIV, FPU). Each cycle it grants at most one register write, using round-robin among the units, and registers the winner onto the WB port. The in-order pipeline has priority by default; a starvation counter per unit bounds how long that priority can block a unit.

---
 rtl/wb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back port arbiter: merges the in-order pipeline result and the MUL,
// DIV and FPU completions onto the single register-file write port. The
// pipeline wins by default. Units share round-robin order, and a per-unit
// starvation counter bounds how long the pipeline can block a unit.
module wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in_pipe,
  output logic        ready_out_pipe,
  input  logic        rd_wena_pipe,
  input  logic [5:0]  rd_addr_pipe,
  input  logic [31:0] rd_data_pipe,
  input  logic        valid_in_mul,
  output logic        ready_out_mul,
  input  logic [5:0]  rd_addr_mul,
  input  logic [31:0] rd_data_mul,
  input  logic        valid_in_div,
  output logic        ready_out_div,
  input  logic [5:0]  rd_addr_div,
  input  logic [31:0] rd_data_div,
  input  logic        valid_in_fpu,
  output logic        ready_out_fpu,
  input  logic        rd_wena_fpu,
  input  logic [5:0]  rd_addr_fpu,
  input  logic [31:0] rd_data_fpu,
  output logic        rd_wena_WB,
  output logic [5:0]  rd_addr_WB,
  output logic [31:0] rd_data_WB,
  output logic [1:0]  wb_src_WB
);

  localparam int              DATA_W  = 32;
  localparam int              ADDR_W  = 6;
  localparam int              CNT_W   = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  localparam logic [1:0] SRC_PIPE = 2'd0;
  localparam logic [1:0] SRC_MUL  = 2'd1;
  localparam logic [1:0] SRC_DIV  = 2'd2;
  localparam logic [1:0] SRC_FPU  = 2'd3;

  // First requesting unit after 'last' in the cyclic order 1->2->3->1.
  // Result is {found, unit}.
  function automatic logic [2:0] rr_pick(input logic [3:1] req, input logic [1:0] last);
    logic [1:0] u;
    logic [2:0] r;
    r = 3'b000;
    u = last;
    for (int i = 0; i < 3; i++) begin
      u = (u == 2'd3) ? 2'd1 : u + 2'd1;
      if (!r[2] && req[u]) r = {1'b1, u};
    end
    return r;
  endfunction

  // Saturating starvation count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= MAX_CNT) ? MAX_CNT : c + 1'b1;
  endfunction

  logic [1:0]        rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  cnt_q [1:3];
  logic [CNT_W-1:0]  cnt_d [1:3];
  logic              wena_q, wena_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        src_q, src_d;

  logic              wreq_pipe;
  logic [3:1]        vld_u;
  logic [3:1]        wreq_u;
  logic [3:1]        starved;
  logic [2:0]        pick_starved;
  logic [2:0]        pick_unit;
  logic              gnt_vld;
  logic [1:0]        gnt_src;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grant decision: starved unit, then pipe, then any unit in round-robin order.
  always_comb begin
    wreq_pipe = valid_in_pipe && rd_wena_pipe;
    vld_u     = {valid_in_fpu, valid_in_div, valid_in_mul};
    wreq_u    = {valid_in_fpu && rd_wena_fpu, valid_in_div, valid_in_mul};
    for (int u = 1; u <= 3; u++) begin
      starved[u] = wreq_u[u] && (cnt_q[u] == MAX_CNT);
    end
    pick_starved = rr_pick(starved, rr_last_q);
    pick_unit    = rr_pick(wreq_u, rr_last_q);
    gnt_vld = 1'b0;
    gnt_src = SRC_PIPE;
    if (!reset) begin
      if (pick_starved[2]) begin
        gnt_vld = 1'b1;
        gnt_src = pick_starved[1:0];
      end else if (wreq_pipe) begin
        gnt_vld = 1'b1;
        gnt_src = SRC_PIPE;
      end else if (pick_unit[2]) begin
        gnt_vld = 1'b1;
        gnt_src = pick_unit[1:0];
      end
    end
  end

  // Handshake readies; non-writing pipe/FPU requests are always accepted.
  always_comb begin
    ready_out_pipe = !reset && valid_in_pipe &&
                     (!rd_wena_pipe || (gnt_vld && gnt_src == SRC_PIPE));
    ready_out_mul  = gnt_vld && gnt_src == SRC_MUL;
    ready_out_div  = gnt_vld && gnt_src == SRC_DIV;
    ready_out_fpu  = !reset && valid_in_fpu &&
                     (!rd_wena_fpu || (gnt_vld && gnt_src == SRC_FPU));
  end

  // Next-state: winner's payload, round-robin pointer and starvation counters.
  always_comb begin
    unique case (gnt_src)
      SRC_MUL: begin sel_addr = rd_addr_mul;  sel_data = rd_data_mul;  end
      SRC_DIV: begin sel_addr = rd_addr_div;  sel_data = rd_data_div;  end
      SRC_FPU: begin sel_addr = rd_addr_fpu;  sel_data = rd_data_fpu;  end
      default: begin sel_addr = rd_addr_pipe; sel_data = rd_data_pipe; end
    endcase
    wena_d    = gnt_vld;
    addr_d    = gnt_vld ? sel_addr : '0;
    data_d    = gnt_vld ? sel_data : '0;
    src_d     = gnt_vld ? gnt_src  : '0;
    rr_last_d = (gnt_vld && gnt_src != SRC_PIPE) ? gnt_src : rr_last_q;
    for (int u = 1; u <= 3; u++) begin
      if (!vld_u[u])                          cnt_d[u] = '0;
      else if (gnt_vld && gnt_src == 2'(u))   cnt_d[u] = '0;
      else if (wreq_u[u])                     cnt_d[u] = sat_inc(cnt_q[u]);
      else                                    cnt_d[u] = cnt_q[u];
    end
  end

  // State and WB register; reset clears everything and points round-robin at FPU so MUL goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= SRC_FPU;
      for (int u = 1; u <= 3; u++) cnt_q[u] <= '0;
      wena_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      src_q     <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      for (int u = 1; u <= 3; u++) cnt_q[u] <= cnt_d[u];
      wena_q    <= wena_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      src_q     <= src_d;
    end
  end

  assign rd_wena_WB = wena_q;
  assign rd_addr_WB = addr_q;
  assign rd_data_WB = data_q;
  assign wb_src_WB  = src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: each stimulus cycle queues the expected
// readies (same cycle) and the expected WB port contents (next cycle); a
// monitor on the falling edge pops and compares.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in_pipe, ready_out_pipe, rd_wena_pipe;
  logic [5:0]  rd_addr_pipe;
  logic [31:0] rd_data_pipe;
  logic        valid_in_mul, ready_out_mul;
  logic [5:0]  rd_addr_mul;
  logic [31:0] rd_data_mul;
  logic        valid_in_div, ready_out_div;
  logic [5:0]  rd_addr_div;
  logic [31:0] rd_data_div;
  logic        valid_in_fpu, ready_out_fpu, rd_wena_fpu;
  logic [5:0]  rd_addr_fpu;
  logic [31:0] rd_data_fpu;
  logic        rd_wena_WB;
  logic [5:0]  rd_addr_WB;
  logic [31:0] rd_data_WB;
  logic [1:0]  wb_src_WB;

  wb_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .valid_in_pipe(valid_in_pipe), .ready_out_pipe(ready_out_pipe),
    .rd_wena_pipe(rd_wena_pipe), .rd_addr_pipe(rd_addr_pipe), .rd_data_pipe(rd_data_pipe),
    .valid_in_mul(valid_in_mul), .ready_out_mul(ready_out_mul),
    .rd_addr_mul(rd_addr_mul), .rd_data_mul(rd_data_mul),
    .valid_in_div(valid_in_div), .ready_out_div(ready_out_div),
    .rd_addr_div(rd_addr_div), .rd_data_div(rd_data_div),
    .valid_in_fpu(valid_in_fpu), .ready_out_fpu(ready_out_fpu),
    .rd_wena_fpu(rd_wena_fpu), .rd_addr_fpu(rd_addr_fpu), .rd_data_fpu(rd_data_fpu),
    .rd_wena_WB(rd_wena_WB), .rd_addr_WB(rd_addr_WB),
    .rd_data_WB(rd_data_WB), .wb_src_WB(wb_src_WB)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [3:0]  rdy;   // {pipe, mul, div, fpu}
    string       name;
  } rdy_exp_t;

  typedef struct {
    int          due;
    logic        wena;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [1:0]  src;
    string       name;
  } wb_exp_t;

  rdy_exp_t rdy_q[$];
  wb_exp_t  wb_q[$];
  int checks = 0;
  int passed = 0;

  // Monitor: compare whatever expectations fall due in this cycle.
  always @(negedge clk) begin
    while (rdy_q.size() > 0 && rdy_q[0].due == cyc) begin
      rdy_exp_t e;
      logic [3:0] act;
      e   = rdy_q.pop_front();
      act = {ready_out_pipe, ready_out_mul, ready_out_div, ready_out_fpu};
      checks++;
      if (act === e.rdy) passed++;
      else $display("FAIL %s ready{pipe,mul,div,fpu}: got %b expected %b", e.name, act, e.rdy);
    end
    while (wb_q.size() > 0 && wb_q[0].due == cyc) begin
      wb_exp_t w;
      w = wb_q.pop_front();
      checks++;
      if (rd_wena_WB === w.wena && rd_addr_WB === w.addr &&
          rd_data_WB === w.data && wb_src_WB === w.src) passed++;
      else $display("FAIL %s wb(wena,addr,data,src): got %b,%0d,%h,%0d expected %b,%0d,%h,%0d",
                    w.name, rd_wena_WB, rd_addr_WB, rd_data_WB, wb_src_WB,
                    w.wena, w.addr, w.data, w.src);
    end
  end

  // Queue expectations for the inputs currently driven, then advance one cycle.
  task automatic step(input string name, input logic [3:0] rdy, input logic wena,
                      input logic [5:0] addr, input logic [31:0] data, input logic [1:0] src);
    rdy_q.push_back('{due: cyc, rdy: rdy, name: name});
    wb_q.push_back('{due: cyc + 1, wena: wena, addr: addr, data: data, src: src, name: name});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name);
    valid_in_pipe = 0; valid_in_mul = 0; valid_in_div = 0; valid_in_fpu = 0;
    step(name, 4'b0000, 0, 6'd0, 32'h0, 2'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    reset = 1;
    valid_in_pipe = 0; rd_wena_pipe = 0; rd_addr_pipe = 0; rd_data_pipe = 0;
    valid_in_mul = 0;  rd_addr_mul = 0;  rd_data_mul = 0;
    valid_in_div = 0;  rd_addr_div = 0;  rd_data_div = 0;
    valid_in_fpu = 0;  rd_wena_fpu = 0;  rd_addr_fpu = 0; rd_data_fpu = 0;
    @(posedge clk);
    #1;

    // Requests during reset are not granted.
    valid_in_mul = 1; rd_addr_mul = 6'd5; rd_data_mul = 32'h0000_1234;
    step("reset_hold", 4'b0000, 0, 6'd0, 32'h0, 2'd0);
    reset = 0;

    // MUL alone just out of reset.
    step("mul_alone", 4'b0100, 1, 6'd5, 32'h0000_1234, 2'd1);
    idle("mul_after");

    // Starvation: pipe wins four cycles, DIV takes cycle 4, pipe again in cycle 5.
    valid_in_pipe = 1; rd_wena_pipe = 1; rd_addr_pipe = 6'd7; rd_data_pipe = 32'hAAAA_0001;
    valid_in_div = 1;  rd_addr_div = 6'd9; rd_data_div = 32'hD1D1_D1D1;
    for (int i = 0; i < 4; i++) step($sformatf("starve_pipe%0d", i), 4'b1000, 1, 6'd7, 32'hAAAA_0001, 2'd0);
    step("starve_div", 4'b0010, 1, 6'd9, 32'hD1D1_D1D1, 2'd2);
    step("starve_pipe5", 4'b1000, 1, 6'd7, 32'hAAAA_0001, 2'd0);
    idle("starve_after");

    // Reset mid-operation with DIV's counter at 3.
    valid_in_pipe = 1; valid_in_div = 1;
    for (int i = 0; i < 3; i++) step($sformatf("rst_pre%0d", i), 4'b1000, 1, 6'd7, 32'hAAAA_0001, 2'd0);
    reset = 1;
    step("rst_mid", 4'b0000, 0, 6'd0, 32'h0, 2'd0);
    reset = 0;
    for (int i = 0; i < 4; i++) step($sformatf("rst_post_pipe%0d", i), 4'b1000, 1, 6'd7, 32'hAAAA_0001, 2'd0);
    step("rst_post_div", 4'b0010, 1, 6'd9, 32'hD1D1_D1D1, 2'd2);
    idle("rst_after");

    // Return the round-robin pointer to its reset value.
    reset = 1;
    idle("rr_reset");
    reset = 0;

    // Round-robin among units, pipe idle.
    rd_addr_mul = 6'd1;  rd_data_mul = 32'h0000_0011;
    rd_addr_div = 6'd2;  rd_data_div = 32'h0000_0022;
    rd_addr_fpu = 6'd35; rd_data_fpu = 32'h0000_0033; rd_wena_fpu = 1;
    valid_in_mul = 1; valid_in_div = 1; valid_in_fpu = 1;
    step("rr_mul", 4'b0100, 1, 6'd1, 32'h0000_0011, 2'd1);
    valid_in_mul = 0;
    step("rr_div", 4'b0010, 1, 6'd2, 32'h0000_0022, 2'd2);
    valid_in_mul = 1; valid_in_div = 0;
    step("rr_fpu", 4'b0001, 1, 6'd35, 32'h0000_0033, 2'd3);
    valid_in_div = 1; valid_in_fpu = 0;
    step("rr_mul2", 4'b0100, 1, 6'd1, 32'h0000_0011, 2'd1);
    idle("rr_after");

    // Non-writing pipe completes alongside an FPU write.
    valid_in_pipe = 1; rd_wena_pipe = 0; rd_addr_pipe = 6'd10;
    valid_in_fpu = 1;  rd_wena_fpu = 1;  rd_addr_fpu = 6'd33; rd_data_fpu = 32'h0000_F00D;
    step("bypass_pipe", 4'b1001, 1, 6'd33, 32'h0000_F00D, 2'd3);
    idle("bypass_after");

    // Non-writing FPU alongside a pipe write to x0 while MUL waits.
    valid_in_pipe = 1; rd_wena_pipe = 1; rd_addr_pipe = 6'd0; rd_data_pipe = 32'h0000_0005;
    valid_in_fpu = 1;  rd_wena_fpu = 0;
    valid_in_mul = 1;  rd_addr_mul = 6'd4; rd_data_mul = 32'h0000_0044;
    step("bypass_fpu_x0", 4'b1001, 1, 6'd0, 32'h0000_0005, 2'd0);
    valid_in_pipe = 0; valid_in_fpu = 0;
    step("mul_after_pipe", 4'b0100, 1, 6'd4, 32'h0000_0044, 2'd1);
    idle("final_idle");

    @(posedge clk);
    #1;
    if (rdy_q.size() != 0 || wb_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", rdy_q.size() + wb_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
